noc_traffic_source: RTL and testbench
=====================================

Name: noc_traffic_source

Overview:
- Per-node synthetic packet injector; one instance per NoC node.
- Clocked by that node's own `clk[i]`, reset and gated by the shared `send` from the clock/reset stimulus stage.
- Generates multi-flit packets with pseudo-random destination and injection timing.
- Presents flits to the local router input port over a valid/ready handshake.

Parameters:
- NODE_ID, 0, this node's ID (0..NUM_NODES-1); placed in the src field.
- NUM_NODES, 9, node count; 2..16.
- PKT_LEN, 4, flits per packet; 1..16383.
- INJ_RATE, 64, injection probability per IDLE cycle, in units of 1/256; 0..256; 256 = always inject.
- SEED, 16'hACE1, LFSR seed; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  node clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- send  input  1  injection enable; may change at any time.
- ready_in  input  1  router can accept a flit this cycle.
- valid_out  output  1  flit_out holds a valid flit.
- flit_out  output  32  flit.
- busy  output  1  a packet is in progress (state SEND).

Behaviour:
- Flit format:
  - [31:30] type: 00 head-tail, 01 head, 10 body, 11 tail.
  - [29:26] dest.
  - [25:22] src = NODE_ID.
  - [21:14] seq.
  - [13:0] flit index within packet (head = 0).
- Reset (reset=0, asynchronous): valid_out=0, flit_out=0, busy=0, state=IDLE, seq=0, flit index=0, LFSR=SEED.
- LFSR: 16-bit Galois, mask 16'hB400. Shifts every clock edge while out of reset, independent of state.
- States:
  - IDLE:
    - Each edge, inject when send=1 and (INJ_RATE==256 or lfsr[7:0] < INJ_RATE). Current pre-shift LFSR value is used.
    - On inject: dest = lfsr[15:8] mod NUM_NODES; if that equals NODE_ID, dest = (dest+1) mod NUM_NODES.
    - On inject: register the head flit, valid_out=1, busy=1, go to SEND.
    - Latency: head visible on the edge that makes the decision.
  - SEND:
    - A transfer occurs when valid_out && ready_in at a rising edge.
    - On transfer of a non-last flit: index+1; next flit type is body, or tail when index+1 == PKT_LEN-1.
    - dest, src and seq are held for the whole packet.
    - On transfer of the last flit: valid_out=0, busy=0, seq+1 (8-bit, wraps 255→0), go to IDLE.
- PKT_LEN=1: single flit of type 00; SEND lasts until its transfer.
- Inter-packet gap:
  - Minimum 1 idle cycle between a tail transfer and the next head (injection is only evaluated in IDLE).
  - Sustained pattern at INJ_RATE=256 with ready_in=1: PKT_LEN valid cycles, then 1 idle cycle.
- Backpressure: while valid_out=1 and ready_in=0, flit_out and valid_out hold stable. No flit is ever dropped or duplicated.
- send=0 during SEND: the current packet completes normally; no new injection afterwards.
- send toggling in IDLE: evaluated per edge; no memory of earlier requests.
- INJ_RATE=0: valid_out never asserts.
- reset asserted mid-packet: all outputs clear immediately; the partial packet is abandoned; seq restarts at 0.
- Invariants:
  - dest < NUM_NODES and dest != NODE_ID always.
  - valid_out never drops without a transfer, except on reset.

Optional Feature:
- Macro: TRAFFIC_SRC_STATS_EN.
- Defined:
  - Adds output `pkt_sent[31:0]`: increments on each last-flit transfer.
  - Adds output `stall_cycles[31:0]`: increments each edge with valid_out=1 and ready_in=0.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 5 cycles with send=1 → valid_out=0, flit_out=0, busy=0 throughout. Release → first head flit has seq=0 and index=0.
- Throughput: PKT_LEN=4, INJ_RATE=256, ready_in=1, NODE_ID=2 → repeating 4-valid/1-idle pattern. Types 01,10,10,11; indices 0..3; src=2; seq 0,1,2,… across packets; seq wraps 255→0 on packet 257.
- Backpressure: ready_in=0 for 3 cycles while flit index 1 is presented → flit_out bit-identical and valid_out=1 for all 3 cycles. Index 2 follows the first edge with ready_in=1. Stats: stall_cycles += 3.
- send deassert: set send=0 after the head transfer → body, body, tail still delivered; then valid_out stays 0 for 100 cycles; busy=0.
- Random sweep: INJ_RATE=64, 1000 packets, random ready_in → every dest in 0..8 and != NODE_ID. Scoreboard sees no lost or duplicated flits. Stats: pkt_sent=1000.
- Reset mid-packet / edge parameters: assert reset during flit 2 → outputs 0 asynchronously, before the next edge. Separately: INJ_RATE=0 gives no valid in 500 cycles; PKT_LEN=1 gives only type-00 flits.

Source files
------------

// File: rtl/noc_traffic_source_if.sv
// Flit link between a traffic source (master) and the local router input port (slave).
interface noc_traffic_source_if;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] flit_out;
    logic        busy;

    modport master (input ready_in, output valid_out, output flit_out, output busy);
    modport slave  (output ready_in, input valid_out, input flit_out, input busy);
endinterface

// File: rtl/noc_traffic_source.sv
// Per-node synthetic packet injector: LFSR-driven destination and injection timing.
// Optional TRAFFIC_SRC_STATS_EN adds pkt_sent/stall_cycles saturating counters.
module noc_traffic_source #(
    parameter int          NODE_ID   = 0,
    parameter int          NUM_NODES = 9,
    parameter int          PKT_LEN   = 4,
    parameter int          INJ_RATE  = 64,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send,
    noc_traffic_source_if.master  link
`ifdef TRAFFIC_SRC_STATS_EN
    ,
    output logic [31:0]           pkt_sent,
    output logic [31:0]           stall_cycles
`endif
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [13:0] LAST_IDX  = 14'(PKT_LEN - 1);
    localparam logic [3:0]  SRC       = 4'(NODE_ID);
    localparam logic [1:0]  HEAD_TYPE = (PKT_LEN == 1) ? 2'b00 : 2'b01;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  seq_q;
    logic [13:0] idx_q, idx_inc;
    logic [3:0]  dest_q, dest_mod, dest_sel;
    logic [31:0] flit_q;
    logic        valid_q, busy_q;
    logic        rate_hit;

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);
        // 9-bit compare so INJ_RATE up to 255 is exact; 256 short-circuits to always
        rate_hit = (INJ_RATE >= 256) || ({1'b0, lfsr_q[7:0]} < 9'(INJ_RATE));
        dest_mod = 4'(lfsr_q[15:8] % 8'(NUM_NODES));
        dest_sel = dest_mod;
        if (dest_mod == SRC)
            dest_sel = (dest_mod == 4'(NUM_NODES - 1)) ? 4'd0 : dest_mod + 4'd1;
        idx_inc  = idx_q + 14'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            seq_q   <= '0;
            idx_q   <= '0;
            dest_q  <= '0;
            flit_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: begin
                    if (send && rate_hit) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        dest_q  <= dest_sel;
                        flit_q  <= {HEAD_TYPE, dest_sel, SRC, seq_q, 14'd0};
                    end
                end
                SEND: begin
                    if (link.ready_in) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            seq_q   <= seq_q + 8'd1;
                            idx_q   <= '0;
                            flit_q  <= '0;
                        end else begin
                            idx_q  <= idx_inc;
                            flit_q <= {(idx_inc == LAST_IDX) ? 2'b11 : 2'b10,
                                       dest_q, SRC, seq_q, idx_inc};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign link.valid_out = valid_q;
    assign link.flit_out  = flit_q;
    assign link.busy      = busy_q;

`ifdef TRAFFIC_SRC_STATS_EN
    logic [31:0] pkt_q, stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_q   <= '0;
            stall_q <= '0;
        end else begin
            if (valid_q && link.ready_in && (idx_q == LAST_IDX) && (pkt_q != '1))
                pkt_q <= pkt_q + 32'd1;
            if (valid_q && !link.ready_in && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign pkt_sent     = pkt_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_noc_traffic_source.sv
// Bench for noc_traffic_source: four instances checked every cycle against a packet-level model,
// plus directed literal checks. Define TRAFFIC_SRC_STATS_EN to also check the counters.
module tb_noc_traffic_source;

    localparam int NNODES = 9;
    localparam int NID  [4] = '{2, 0, 0, 0};
    localparam int PLEN [4] = '{4, 4, 4, 1};
    localparam int RATE [4] = '{256, 64, 0, 256};

    logic        clk = 1'b0;
    logic        reset;
    logic        send = 1'b0;
    logic        r0 = 1'b1, r1 = 1'b1;
    logic [3:0]  rdy, vld, bsy;
    logic [31:0] flt [4];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    noc_traffic_source_if if0 (), if1 (), if2 (), if3 ();

    assign rdy = {2'b11, r1, r0};
    assign if0.ready_in = rdy[0];
    assign if1.ready_in = rdy[1];
    assign if2.ready_in = rdy[2];
    assign if3.ready_in = rdy[3];
    assign vld = {if3.valid_out, if2.valid_out, if1.valid_out, if0.valid_out};
    assign bsy = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign flt[0] = if0.flit_out;
    assign flt[1] = if1.flit_out;
    assign flt[2] = if2.flit_out;
    assign flt[3] = if3.flit_out;

`ifdef TRAFFIC_SRC_STATS_EN
    logic [31:0] pkt [4], stl [4];
`endif

    noc_traffic_source #(.NODE_ID(2), .NUM_NODES(9), .PKT_LEN(4), .INJ_RATE(256)) u0 (
        .clk(clk), .reset(reset), .send(send), .link(if0)
`ifdef TRAFFIC_SRC_STATS_EN
        , .pkt_sent(pkt[0]), .stall_cycles(stl[0])
`endif
    );
    noc_traffic_source #(.NODE_ID(0), .NUM_NODES(9), .PKT_LEN(4), .INJ_RATE(64)) u1 (
        .clk(clk), .reset(reset), .send(send), .link(if1)
`ifdef TRAFFIC_SRC_STATS_EN
        , .pkt_sent(pkt[1]), .stall_cycles(stl[1])
`endif
    );
    noc_traffic_source #(.NODE_ID(0), .NUM_NODES(9), .PKT_LEN(4), .INJ_RATE(0)) u2 (
        .clk(clk), .reset(reset), .send(send), .link(if2)
`ifdef TRAFFIC_SRC_STATS_EN
        , .pkt_sent(pkt[2]), .stall_cycles(stl[2])
`endif
    );
    noc_traffic_source #(.NODE_ID(0), .NUM_NODES(9), .PKT_LEN(1), .INJ_RATE(256)) u3 (
        .clk(clk), .reset(reset), .send(send), .link(if3)
`ifdef TRAFFIC_SRC_STATS_EN
        , .pkt_sent(pkt[3]), .stall_cycles(stl[3])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: a whole packet is built at injection and consumed flit by flit.
    logic [15:0] m_lfsr  [4] = '{16'hACE1, 16'hACE1, 16'hACE1, 16'hACE1};
    logic [7:0]  m_seq   [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [31:0] m_flits [4][4];
    logic        m_act   [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          m_pos   [4] = '{0, 0, 0, 0};
    int          m_pkts  [4] = '{0, 0, 0, 0};
    int          m_stall [4] = '{0, 0, 0, 0};

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [1:0] ftype(input int i, input int len);
        if (len == 1)       return 2'b00;
        if (i == 0)         return 2'b01;
        if (i == len - 1)   return 2'b11;
        return 2'b10;
    endfunction

    task automatic model_step(input int k);
        int d;
        if (!reset) begin
            m_lfsr[k] = 16'hACE1; m_act[k] = 1'b0; m_pos[k] = 0;
            m_seq[k] = 8'd0; m_pkts[k] = 0; m_stall[k] = 0;
            return;
        end
        if (m_act[k]) begin
            if (rdy[k]) begin
                m_pos[k]++;
                if (m_pos[k] == PLEN[k]) begin
                    m_act[k] = 1'b0; m_seq[k]++; m_pkts[k]++;
                end
            end else begin
                m_stall[k]++;
            end
        end else if (send && (RATE[k] == 256 || int'(m_lfsr[k][7:0]) < RATE[k])) begin
            d = int'(m_lfsr[k][15:8]) % NNODES;
            if (d == NID[k]) d = (d + 1) % NNODES;
            for (int i = 0; i < PLEN[k]; i++)
                m_flits[k][i] = {ftype(i, PLEN[k]), 4'(d), 4'(NID[k]), m_seq[k], 14'(i)};
            m_act[k] = 1'b1; m_pos[k] = 0;
        end
        m_lfsr[k] = galois(m_lfsr[k]);
    endtask

    int          heads0 = 0, vcount2 = 0;
    logic [7:0]  seq256 = 8'hxx, seq257 = 8'hxx;

    // Model advances on the rising edge; outputs are compared on the falling edge.
    initial begin
        logic [31:0] exp_f, act_f;
        logic [3:0]  d;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 4; k++) model_step(k);
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                exp_f = m_act[k] ? m_flits[k][m_pos[k]] : 32'h0;
                act_f = (m_act[k] || !reset) ? flt[k] : 32'h0;
                check($sformatf("cycle_u%0d", k), {30'd0, vld[k], bsy[k], act_f},
                      {30'd0, m_act[k], m_act[k], exp_f});
`ifdef TRAFFIC_SRC_STATS_EN
                check($sformatf("stats_u%0d", k), {pkt[k], stl[k]},
                      {32'(m_pkts[k]), 32'(m_stall[k])});
`endif
            end
            if (vld[1]) begin
                d = flt[1][29:26];
                check("dest_u1", {63'd0, (d < 4'd9) && (d != 4'd0)}, 64'd1);
            end
            if (vld[3]) check("type_u3", {62'd0, flt[3][31:30]}, 64'd0);
            if (vld[2]) vcount2++;
            if (vld[0] && flt[0][13:0] == 14'd0 && heads0 < 300) begin
                heads0++;
                if (heads0 == 256) seq256 = flt[0][21:14];
                if (heads0 == 257) seq257 = flt[0][21:14];
            end
        end
    end

    // Random backpressure on the INJ_RATE=64 instance.
    initial forever begin
        @(negedge clk);
        r1 = 1'($urandom_range(0, 1));
    end

    initial begin
        int cnt, cnt2, guard;
        logic [31:0] hold;
`ifdef TRAFFIC_SRC_STATS_EN
        logic [31:0] stall0;
`endif
        reset = 1'b0;
        send  = 1'b1;
        r0    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset_u0", {31'd0, vld[0], bsy[0], flt[0]}, 64'd0);
        end
        reset = 1'b1;

        // Seed ACE1: dest = 0xAC % 9 = 1 for both nodes 2 and 0; low byte 0xE1 >= 64.
        @(posedge clk); #1;
        check("first_head_u0", {31'd0, vld[0], flt[0]}, {31'd0, 1'b1, 32'h4480_0000});
        check("first_flit_u3", {31'd0, vld[3], flt[3]}, {31'd0, 1'b1, 32'h0400_0000});
        check("first_idle_u1", {63'd0, vld[1]}, 64'd0);

        cnt = 0;
        repeat (50) begin
            @(posedge clk); #1;
            cnt += int'(vld[0]);
        end
        check("pattern_4_1", 64'(cnt), 64'd40);

        guard = 0;
        while (m_pkts[1] < 1000 && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        check("sweep_bound", {63'd0, m_pkts[1] >= 1000}, 64'd1);
`ifdef TRAFFIC_SRC_STATS_EN
        check("pkt_sent_1000", {32'd0, pkt[1]}, 64'd1000);
`endif
        check("heads_seen", {63'd0, heads0 >= 257}, 64'd1);
        check("seq_256th", {56'd0, seq256}, 64'd255);
        check("seq_wrap", {56'd0, seq257}, 64'd0);

        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(vld[0] && flt[0][13:0] == 14'd1) && guard < 20);
        check("bp_found", {63'd0, guard < 20}, 64'd1);
        r0 = 1'b0;
        hold = flt[0];
`ifdef TRAFFIC_SRC_STATS_EN
        stall0 = stl[0];
`endif
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", {31'd0, vld[0], flt[0]}, {31'd0, 1'b1, hold});
        end
        r0 = 1'b1;
        @(negedge clk);
        check("bp_next_idx", {50'd0, flt[0][13:0]}, 64'd2);
`ifdef TRAFFIC_SRC_STATS_EN
        check("bp_stall_delta", {32'd0, stl[0] - stall0}, 64'd3);
`endif

        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(vld[0] && flt[0][13:0] == 14'd1) && guard < 20);
        check("sd_found", {63'd0, guard < 20}, 64'd1);
        send = 1'b0;
        cnt = 0;
        repeat (2) begin @(negedge clk); cnt += int'(vld[0]); end
        check("sd_tail_delivered", 64'(cnt), 64'd2);
        cnt2 = 0;
        repeat (100) begin @(negedge clk); cnt2 += int'(vld[0]) + int'(bsy[0]); end
        check("sd_idle_100", 64'(cnt2), 64'd0);

        send = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end
        while (!(vld[0] && flt[0][13:0] == 14'd2) && guard < 20);
        check("mr_found", {63'd0, guard < 20}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {31'd0, vld[0], bsy[0], flt[0]}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rehead_seq0", {31'd0, vld[0], flt[0]}, {31'd0, 1'b1, 32'h4480_0000});

        repeat (20) @(negedge clk);
        check("rate0_never_valid", 64'(vcount2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
